// File: rtl/lpddr5_dram_responder_pkg.sv
// Shared LPDDR5 command encoding and default device timing/geometry.
// The controller imports the same enum package.
package lpddr5_controller_enum;
    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } dram_cmd_t;
endpackage

package lpddr5_params;
    localparam int CHANNELS     = 2;
    localparam int BURST_LENGTH = 16;
    localparam int DATA_BITS    = 32;
    localparam int BANK_BITS    = 2;
    localparam int ROW_BITS     = 4;
    localparam int COL_BITS     = 4;
    localparam int T_RCD        = 4;
    localparam int T_RP         = 4;
    localparam int T_RFC        = 8;
    localparam int T_RL         = 6;
    localparam int T_WL         = 4;

    function automatic int tmax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/lpddr5_dram_responder_if.sv
// Controller <-> DRAM command/data bus.
// master = controller side, slave = device side.
interface lpddr5_dram_responder_if #(
    parameter int CHANNELS     = lpddr5_params::CHANNELS,
    parameter int BURST_LENGTH = lpddr5_params::BURST_LENGTH,
    parameter int DATA_BITS    = lpddr5_params::DATA_BITS,
    parameter int BANK_BITS    = lpddr5_params::BANK_BITS,
    parameter int ROW_BITS     = lpddr5_params::ROW_BITS,
    parameter int COL_BITS     = lpddr5_params::COL_BITS
) ();
    import lpddr5_controller_enum::*;

    localparam int ADDR_WIDTH = ROW_BITS + BANK_BITS + COL_BITS;

    dram_cmd_t                                           dram_cmd;
    logic [ADDR_WIDTH-1:0]                               dram_addr;
    logic [CHANNELS-1:0][BURST_LENGTH-1:0][DATA_BITS-1:0] dram_wdata;
    logic [CHANNELS-1:0][BURST_LENGTH-1:0][DATA_BITS-1:0] dram_rdata;
    logic                                                dram_ready;
    logic                                                dram_err;

    modport master (
        output dram_cmd, dram_addr, dram_wdata,
        input  dram_rdata, dram_ready, dram_err
    );

    modport slave (
        input  dram_cmd, dram_addr, dram_wdata,
        output dram_rdata, dram_ready, dram_err
    );
endinterface

// File: rtl/lpddr5_dram_responder_bank_tracker.sv
// Per-bank open/active-row state and command legality check.
module lpddr5_bank_tracker
    import lpddr5_controller_enum::*;
#(
    parameter int BANK_BITS = lpddr5_params::BANK_BITS,
    parameter int ROW_BITS  = lpddr5_params::ROW_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 upd_act,
    input  logic                 upd_pre,
    input  logic                 upd_close_all,
    input  logic [BANK_BITS-1:0] upd_bank,
    input  logic [ROW_BITS-1:0]  upd_row,
    input  dram_cmd_t            cmd,
    input  logic [BANK_BITS-1:0] bank,
    output logic                 legal,
    output logic [ROW_BITS-1:0]  row
);
    localparam int BANK_NUM = 2 ** BANK_BITS;

    logic [BANK_NUM-1:0]               bank_open;
    logic [BANK_NUM-1:0][ROW_BITS-1:0] active_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_open  <= '0;
            active_row <= '0;
        end else if (upd_close_all) begin
            bank_open <= '0;
        end else if (upd_act) begin
            bank_open[upd_bank]  <= 1'b1;
            active_row[upd_bank] <= upd_row;
        end else if (upd_pre) begin
            bank_open[upd_bank] <= 1'b0;
        end
    end

    always_comb begin
        legal = 1'b1;
        case (cmd)
            CMD_ACT:         legal = !bank_open[bank];
            CMD_RD, CMD_WR:  legal = bank_open[bank];
            CMD_REF:         legal = ~|bank_open;
            default:         legal = 1'b1;
        endcase
    end

    assign row = active_row[bank];
endmodule

// File: rtl/lpddr5_dram_responder.sv
// LPDDR5 device-side responder: bank state, fixed busy latencies,
// burst storage per channel.
module lpddr5_dram_responder
    import lpddr5_controller_enum::*;
#(
    parameter int CHANNELS     = lpddr5_params::CHANNELS,
    parameter int BURST_LENGTH = lpddr5_params::BURST_LENGTH,
    parameter int DATA_BITS    = lpddr5_params::DATA_BITS,
    parameter int BANK_BITS    = lpddr5_params::BANK_BITS,
    parameter int ROW_BITS     = lpddr5_params::ROW_BITS,
    parameter int COL_BITS     = lpddr5_params::COL_BITS,
    parameter int T_RCD        = lpddr5_params::T_RCD,
    parameter int T_RP         = lpddr5_params::T_RP,
    parameter int T_RFC        = lpddr5_params::T_RFC,
    parameter int T_RL         = lpddr5_params::T_RL,
    parameter int T_WL         = lpddr5_params::T_WL
) (
    input logic clk,
    input logic rst_n,
    lpddr5_dram_responder_if.slave bus
);
    localparam int LOC_BITS = ROW_BITS + BANK_BITS + COL_BITS;
    localparam int DEPTH    = 2 ** LOC_BITS;
    localparam int T_MAX    = lpddr5_params::tmax(
        lpddr5_params::tmax(lpddr5_params::tmax(T_RCD, T_RP), T_RFC),
        lpddr5_params::tmax(T_RL, T_WL));
    localparam int CNT_W    = $clog2(T_MAX) + 1;

    typedef enum logic {IDLE, BUSY} state_t;
    typedef logic [BURST_LENGTH-1:0][DATA_BITS-1:0] beat_blk_t;

    state_t                state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d, load;
    dram_cmd_t             cmd, op_q;
    logic [ROW_BITS-1:0]   row_f, open_row;
    logic [BANK_BITS-1:0]  bank_f;
    logic [COL_BITS-1:0]   col_f;
    logic [LOC_BITS-1:0]   loc, rd_loc;
    logic                  req, legal, accept, err_d, err_q, rd_done;
    beat_blk_t             rdata_q [CHANNELS];
    beat_blk_t             mem [CHANNELS][DEPTH];

    assign cmd    = bus.dram_cmd;
    assign row_f  = bus.dram_addr[LOC_BITS-1 -: ROW_BITS];
    assign bank_f = bus.dram_addr[COL_BITS +: BANK_BITS];
    assign col_f  = bus.dram_addr[COL_BITS-1:0];
    // Column accesses always target the bank's open row, not the address row.
    assign loc    = {open_row, bank_f, col_f};

    assign req     = (cmd != CMD_NOP);
    assign accept  = (state == IDLE) && req && legal;
    assign rd_done = (state == BUSY) && (cnt == '0) && (op_q == CMD_RD);

    lpddr5_bank_tracker #(
        .BANK_BITS(BANK_BITS),
        .ROW_BITS (ROW_BITS)
    ) u_bank_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .upd_act      (accept && (cmd == CMD_ACT)),
        .upd_pre      (accept && (cmd == CMD_PRE)),
        .upd_close_all(accept && (cmd == CMD_REF)),
        .upd_bank     (bank_f),
        .upd_row      (row_f),
        .cmd          (cmd),
        .bank         (bank_f),
        .legal        (legal),
        .row          (open_row)
    );

    always_comb begin
        load = '0;
        case (cmd)
            CMD_ACT: load = CNT_W'(T_RCD - 1);
            CMD_PRE: load = CNT_W'(T_RP - 1);
            CMD_REF: load = CNT_W'(T_RFC - 1);
            CMD_RD:  load = CNT_W'(T_RL - 1);
            CMD_WR:  load = CNT_W'(T_WL - 1);
            default: load = '0;
        endcase
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (legal) begin
                        state_d = BUSY;
                        cnt_d   = load;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                err_d = req;
                if (cnt == '0) state_d = IDLE;
                else           cnt_d   = cnt - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            err_q  <= 1'b0;
            op_q   <= CMD_NOP;
            rd_loc <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) rdata_q[ch] <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            err_q <= err_d;
            if (accept) begin
                op_q   <= cmd;
                rd_loc <= loc;
            end
            if (rd_done) begin
                for (int ch = 0; ch < CHANNELS; ch++)
                    rdata_q[ch] <= mem[ch][rd_loc];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && (cmd == CMD_WR)) begin
            for (int ch = 0; ch < CHANNELS; ch++)
                mem[ch][loc] <= bus.dram_wdata[ch];
        end
    end

    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++)
            bus.dram_rdata[ch] = rdata_q[ch];
    end

    assign bus.dram_ready = (state == IDLE);
    assign bus.dram_err   = err_q;
endmodule
